// File: rtl/cascaded_bcd_counter_if.sv
// Handshake-free control/status bundle for cascaded_bcd_counter.
// Scan outputs exist only when CASCADED_BCD_COUNTER_DIGIT_SCAN_EN is defined.
interface cascaded_bcd_counter_if #(
  parameter int DIGITS = 2
);
  logic                  enable;
  logic                  up;
  logic                  preset;
  logic [4*DIGITS-1:0]   presetVal;
  logic [4*DIGITS-1:0]   count;
  logic                  overflow;
  logic                  zero;
`ifdef CASCADED_BCD_COUNTER_DIGIT_SCAN_EN
  logic [3:0]            digit;
  logic [DIGITS-1:0]     digitSel;
`endif

`ifdef CASCADED_BCD_COUNTER_DIGIT_SCAN_EN
  modport master (
    output enable, up, preset, presetVal,
    input  count, overflow, zero, digit, digitSel
  );
  modport slave (
    input  enable, up, preset, presetVal,
    output count, overflow, zero, digit, digitSel
  );
`else
  modport master (
    output enable, up, preset, presetVal,
    input  count, overflow, zero
  );
  modport slave (
    input  enable, up, preset, presetVal,
    output count, overflow, zero
  );
`endif
endinterface

// File: rtl/cascaded_bcd_counter.sv
// N-digit cascaded BCD up/down counter with clamped preset and one-cycle wrap flag.
// Define CASCADED_BCD_COUNTER_DIGIT_SCAN_EN to add a time-multiplexed digit scan output.
module cascaded_bcd_counter #(
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 1000
) (
  input logic                    i_clk,
  input logic                    i_rst,
  cascaded_bcd_counter_if.slave  bus
);

  if (DIGITS < 1 || DIGITS > 8 || SCAN_DIV < 1) begin : g_badParam
    $error("cascaded_bcd_counter: invalid parameter value");
  end

  logic [DIGITS-1:0][3:0] r_count;
  logic                   r_overflow;
  logic [DIGITS-1:0][3:0] w_stepCount;
  logic [DIGITS-1:0][3:0] w_presetCount;
  logic [DIGITS:0]        w_chain;

  // w_chain[k] is high when every digit below k sits at its limit, so digit k moves.
  always_comb begin
    w_chain       = '0;
    w_chain[0]    = 1'b1;
    w_stepCount   = r_count;
    w_presetCount = '0;
    for (int k = 0; k < DIGITS; k++) begin
      w_presetCount[k] = (bus.presetVal[4*k +: 4] > 4'd9) ? 4'd9 : bus.presetVal[4*k +: 4];
      if (bus.up) begin
        w_chain[k+1] = w_chain[k] & (r_count[k] == 4'd9);
        if (w_chain[k]) begin
          w_stepCount[k] = (r_count[k] == 4'd9) ? 4'd0 : r_count[k] + 4'd1;
        end
      end else begin
        w_chain[k+1] = w_chain[k] & (r_count[k] == 4'd0);
        if (w_chain[k]) begin
          w_stepCount[k] = (r_count[k] == 4'd0) ? 4'd9 : r_count[k] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (bus.preset) begin
      r_count    <= w_presetCount;
      r_overflow <= 1'b0;
    end else if (bus.enable) begin
      r_count    <= w_stepCount;
      r_overflow <= w_chain[DIGITS];
    end else begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
  assign bus.zero     = (r_count == '0);

`ifdef CASCADED_BCD_COUNTER_DIGIT_SCAN_EN
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIV_W-1:0] r_div;
  logic [IDX_W-1:0] r_idx;
  logic [DIGITS-1:0] w_digitSel;

  // Scan runs free of preset/enable so the display refresh rate never stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_comb begin
    w_digitSel        = '0;
    w_digitSel[r_idx] = 1'b1;
  end

  assign bus.digitSel = w_digitSel;
  assign bus.digit    = r_count[r_idx];
`endif

endmodule

// File: tb/tb_cascaded_bcd_counter.sv
// Scoreboard bench for cascaded_bcd_counter: decimal-arithmetic reference model, queued expectations.
// Also checks the scan outputs when CASCADED_BCD_COUNTER_DIGIT_SCAN_EN is defined.
module tb_cascaded_bcd_counter;
  localparam int DIGITS   = 2;
  localparam int SCAN_DIV = 4;

  typedef struct {
    logic [4*DIGITS-1:0] count;
    logic                overflow;
    logic                zero;
    logic [3:0]          digit;
    logic [DIGITS-1:0]   digitSel;
  } expect_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cascaded_bcd_counter_if #(.DIGITS(DIGITS)) bus ();

  cascaded_bcd_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  expect_t expQ[$];
  int      compared   = 0;
  int      mismatched = 0;
  int      modelVal   = 0;
  int      scanCycles = 0;
  int      maxVal;

  function automatic logic [4*DIGITS-1:0] toBcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int clampValue(input logic [4*DIGITS-1:0] pv);
    int v;
    int w;
    int d;
    v = 0;
    w = 1;
    for (int k = 0; k < DIGITS; k++) begin
      d = int'(pv[4*k +: 4]);
      if (d > 9) d = 9;
      v = v + d * w;
      w = w * 10;
    end
    return v;
  endfunction

  // Drive one cycle of inputs and queue the result the next edge must produce.
  task automatic applyStimulus(input logic r, input logic pre, input logic [4*DIGITS-1:0] pv,
                               input logic en, input logic u);
    expect_t e;
    logic [4*DIGITS-1:0] b;
    int idx;
    @(negedge clk);
    rst           = r;
    bus.preset    = pre;
    bus.presetVal = pv;
    bus.enable    = en;
    bus.up        = u;
    e.overflow = 1'b0;
    if (r) begin
      modelVal = 0;
    end else if (pre) begin
      modelVal = clampValue(pv);
    end else if (en && u) begin
      e.overflow = (modelVal == maxVal);
      modelVal   = (modelVal + 1) % (maxVal + 1);
    end else if (en) begin
      e.overflow = (modelVal == 0);
      modelVal   = (modelVal == 0) ? maxVal : modelVal - 1;
    end
    scanCycles = r ? 0 : scanCycles + 1;
    b          = toBcd(modelVal);
    e.count    = b;
    e.zero     = (modelVal == 0);
    idx        = (scanCycles / SCAN_DIV) % DIGITS;
    e.digit    = b[4*idx +: 4];
    e.digitSel = '0;
    e.digitSel[idx] = 1'b1;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, required);
    end
  endtask

  // Monitor: every cycle after an edge, compare DUT outputs with the oldest queued expectation.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("count", 32'(bus.count), 32'(e.count));
        checkOutput("overflow", 32'(bus.overflow), 32'(e.overflow));
        checkOutput("zero", 32'(bus.zero), 32'(e.zero));
`ifdef CASCADED_BCD_COUNTER_DIGIT_SCAN_EN
        if (scanCycles > 0 || rst) begin
          checkOutput("digit", 32'(bus.digit), 32'(e.digit));
          checkOutput("digitSel", 32'(bus.digitSel), 32'(e.digitSel));
        end
`endif
      end
    end
  end

  initial begin
    int waitCycles;
    maxVal = 1;
    for (int k = 0; k < DIGITS; k++) maxVal = maxVal * 10;
    maxVal = maxVal - 1;
    bus.enable    = 1'b0;
    bus.up        = 1'b1;
    bus.preset    = 1'b0;
    bus.presetVal = '0;

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h98, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hAF, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h37, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h50, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h42, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
                    8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
    end
    for (int i = 0; i < 120; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    if (expQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
